// File: rtl/enfasi_pkg.sv
// Shared types and constants for the de-emphasis receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   sample_t    12-bit signed Q1.10 sample
//   FRAC        fractional bits of samples and coefficients
//   SMAX/SMIN   representable sample range
//   sat12()     clamp a 15-bit intermediate sum onto the sample range
package enfasi_pkg;

    typedef logic signed [11:0] sample_t;

    localparam int      FRAC = 10;
    localparam sample_t SMAX = 12'sh7FF;   //  2047
    localparam sample_t SMIN = 12'sh800;   // -2048

    // Clamp a widened sum back into a sample. The 15-bit input covers the
    // full range of x + fb, so no wrap can occur before the comparison.
    function automatic sample_t sat12(input logic signed [14:0] s);
        sample_t r;
        if (s > 15'(SMAX)) begin
            r = SMAX;
        end else if (s < 15'(SMIN)) begin
            r = SMIN;
        end else begin
            r = s[11:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/deenfasi_dp.sv
// Combinational recursion datapath: y = clamp(x + round(A * y_prev)).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates every cycle, the caller decides when to use it.
//
// Ports:
//   i_x      current input sample x[n], signed Q1.10
//   i_yprev  previous valid output y[n-1], signed Q1.10
//   o_y      new output y[n], clamped to the sample range
//   o_ovf    high when o_y is a clamped value
module deenfasi_dp #(
    parameter int                 FRAC = 10,
    parameter logic signed [11:0] A    = 12'sd960
) (
    input  logic signed [11:0] i_x,
    input  logic signed [11:0] i_yprev,
    output logic signed [11:0] o_y,
    output logic               o_ovf
);

    import enfasi_pkg::*;

    // Product of two 12-bit signed operands needs 24 bits; everything
    // downstream is kept at that width so no intermediate can wrap.
    localparam int PW = 24;

    // Half an LSB of the output scale: adding it before the arithmetic
    // shift gives round-half-up (toward +inf) for both signs.
    localparam logic signed [PW-1:0] RND  = PW'(2 ** (FRAC - 1));
    localparam logic signed [PW-1:0] MAXW = PW'(SMAX);
    localparam logic signed [PW-1:0] MINW = PW'(SMIN);

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_yp;
    logic signed [PW-1:0] w_x;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_fb;
    logic signed [PW-1:0] w_sum;

    assign w_a    = PW'(A);
    assign w_yp   = PW'(i_yprev);
    assign w_x    = PW'(i_x);

    assign w_prod = w_a * w_yp;
    assign w_fb   = (w_prod + RND) >>> FRAC;
    assign w_sum  = w_x + w_fb;

    // |x + fb| < 4096, so the low 15 bits carry the full value into sat12.
    assign o_y    = sat12(w_sum[14:0]);
    assign o_ovf  = (w_sum > MAXW) || (w_sum < MINW);

endmodule

// File: rtl/deenfasi_iir.sv
// First-order de-emphasis IIR, y[n] = x[n] + A*y[n-1], inverse of the tx pre-emphasis FIR.
// Latency: 2 edges from p/p_valid to q/q_valid; one sample per clock sustained.
// Backpressure: none; every valid sample is accepted, clear drops the sample presented with it.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   p_valid  p carries a new sample this cycle
//   p        input sample x[n], signed Q1.10
//   clear    synchronous clear of pipeline, filter state and sat flag
//   q        output sample y[n], signed Q1.10, saturated
//   q_valid  one-cycle pulse: q was updated at the last edge
//   sat      sticky: some output was clamped since reset/clear
module deenfasi_iir #(
    parameter int                   W    = 12,
    parameter int                   FRAC = 10,
    parameter logic signed [W-1:0]  A    = 12'sd960
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_valid,
    input  logic signed [W-1:0] p,
    input  logic                clear,
    output logic signed [W-1:0] q,
    output logic                q_valid,
    output logic                sat
);

    // Stage-1 capture of the incoming sample.
    logic signed [W-1:0] r_x;
    logic                r_v1;

    // Stage-2 output register; it is also the y[n-1] state of the recursion.
    logic signed [W-1:0] r_q;
    logic                r_qv;
    logic                r_sat;

    logic signed [W-1:0] w_y;
    logic                w_ovf;

    deenfasi_dp #(
        .FRAC (FRAC),
        .A    (A)
    ) u_dp (
        .i_x     (r_x),
        .i_yprev (r_q),
        .o_y     (w_y),
        .o_ovf   (w_ovf)
    );

    // Stage 1: x only moves on a valid sample so it is stable for stage 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x  <= '0;
            r_v1 <= 1'b0;
        end else if (clear) begin
            // Sample arriving with clear is discarded.
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= p_valid;
            if (p_valid) begin
                r_x <= p;
            end
        end
    end

    // Stage 2: the recursion always feeds back the last valid output, so
    // gaps in p_valid leave the filter state untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            r_qv  <= 1'b0;
            r_sat <= 1'b0;
        end else if (clear) begin
            r_q   <= '0;
            r_qv  <= 1'b0;
            r_sat <= 1'b0;
        end else begin
            r_qv <= r_v1;
            if (r_v1) begin
                r_q <= w_y;
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign q       = r_q;
    assign q_valid = r_qv;
    assign sat     = r_sat;

endmodule

// File: tb/tb_deenfasi_iir.sv
module tb_deenfasi_iir;

    localparam int AC = 960;

    logic               clk;
    logic               rst;
    logic               p_valid;
    logic signed [11:0] p;
    logic               clear;
    logic signed [11:0] q;
    logic               q_valid;
    logic               sat;

    int checks = 0;
    int errors = 0;

    // Reference model: samples waiting to emerge, plus expected outputs.
    int inflight[$];
    int m_q;
    int m_qv;
    int m_sat;

    deenfasi_iir #(
        .W    (12),
        .FRAC (10),
        .A    (12'sd960)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .p_valid (p_valid),
        .p       (p),
        .clear   (clear),
        .q       (q),
        .q_valid (q_valid),
        .sat     (sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int fdiv(input int n, input int d);
        int r;
        r = n / d;
        if ((n % d != 0) && (n < 0)) r = r - 1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        m_q   = 0;
        m_qv  = 0;
        m_sat = 0;
    endtask

    // Model of one clock edge, from the behavioural rules.
    task automatic model_edge(input logic v, input int x, input logic c);
        int xs, fb, s;
        if (c) begin
            model_reset();
        end else begin
            if (inflight.size() > 0) begin
                xs = inflight.pop_front();
                fb = fdiv(AC * m_q + 512, 1024);
                s  = xs + fb;
                if (s > 2047) begin
                    m_q = 2047;  m_sat = 1;
                end else if (s < -2048) begin
                    m_q = -2048; m_sat = 1;
                end else begin
                    m_q = s;
                end
                m_qv = 1;
            end else begin
                m_qv = 0;
            end
            if (v) inflight.push_back(x);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".q"},       q,       m_q);
        chk({tag, ".q_valid"}, q_valid, m_qv);
        chk({tag, ".sat"},     sat,     m_sat);
    endtask

    // Drive inputs away from the edge, clock once, then compare with the model.
    task automatic step(input string tag, input logic v, input int x, input logic c);
        p_valid = v;
        p       = 12'(x);
        clear   = c;
        @(posedge clk);
        #1;
        model_edge(v, x, c);
        check_model(tag);
    endtask

    initial begin
        rst     = 1'b0;
        p_valid = 1'b0;
        p       = '0;
        clear   = 1'b0;
        model_reset();

        // Reset state, including across an edge while held in reset.
        #3;
        chk("rst.q", q, 0);
        chk("rst.q_valid", q_valid, 0);
        chk("rst.sat", sat, 0);
        #5;
        chk("rst_hold.q", q, 0);
        chk("rst_hold.q_valid", q_valid, 0);
        rst = 1'b1;

        // Impulse response and two-edge latency.
        step("imp0", 1'b1, 1024, 1'b0);
        chk("imp_lat.q_valid", q_valid, 0);
        step("imp1", 1'b1, 0, 1'b0);
        chk("imp1.const", q, 1024);
        step("imp2", 1'b1, 0, 1'b0);
        chk("imp2.const", q, 960);
        step("imp3", 1'b1, 0, 1'b0);
        chk("imp3.const", q, 900);
        step("imp4", 1'b1, 0, 1'b0);
        chk("imp4.const", q, 844);
        chk("imp4.sat", sat, 0);

        // Positive saturation.
        step("clr_a", 1'b0, 0, 1'b1);
        step("pos0", 1'b1, 2047, 1'b0);
        step("pos1", 1'b1, 2047, 1'b0);
        chk("pos1.const", q, 2047);
        chk("pos1.sat", sat, 0);
        step("pos2", 1'b1, 2047, 1'b0);
        chk("pos2.const", q, 2047);
        chk("pos2.sat", sat, 1);

        // Clear with p_valid: sample dropped, sticky flag cleared.
        step("clr_pv", 1'b1, -2048, 1'b1);
        chk("clr_pv.q", q, 0);
        chk("clr_pv.sat", sat, 0);

        // Negative saturation.
        step("neg0", 1'b1, -2048, 1'b0);
        chk("neg0.q_valid", q_valid, 0);
        step("neg1", 1'b1, -2048, 1'b0);
        chk("neg1.const", q, -2048);
        step("neg2", 1'b0, 0, 1'b0);
        chk("neg2.const", q, -2048);
        chk("neg2.sat", sat, 1);

        // Valid gaps: q holds, q_valid alternates.
        step("clr_b", 1'b0, 0, 1'b1);
        step("gap0", 1'b1, 1024, 1'b0);
        step("gap1", 1'b0, 0, 1'b0);
        chk("gap1.const", q, 1024);
        step("gap2", 1'b1, 0, 1'b0);
        chk("gap2.q_valid", q_valid, 0);
        chk("gap2.hold", q, 1024);
        step("gap3", 1'b0, 0, 1'b0);
        chk("gap3.const", q, 960);
        step("gap4", 1'b1, 0, 1'b0);
        chk("gap4.q_valid", q_valid, 0);
        step("gap5", 1'b0, 0, 1'b0);
        chk("gap5.const", q, 900);

        // Clear in an impulse tail, then a fresh impulse restarts at 1024.
        step("tail_clr", 1'b1, 0, 1'b1);
        chk("tail_clr.q", q, 0);
        step("rest0", 1'b1, 1024, 1'b0);
        step("rest1", 1'b1, 0, 1'b0);
        chk("rest1.const", q, 1024);

        // Asynchronous reset mid-stream with sat set and a sample in flight.
        step("rs0", 1'b1, 2047, 1'b0);
        step("rs1", 1'b1, 2047, 1'b0);
        step("rs2", 1'b1, 2047, 1'b0);
        chk("rs2.sat", sat, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.q", q, 0);
        chk("arst.q_valid", q_valid, 0);
        chk("arst.sat", sat, 0);
        #3;
        rst = 1'b1;
        model_reset();
        step("post0", 1'b1, 1024, 1'b0);
        chk("post0.q_valid", q_valid, 0);
        step("post1", 1'b1, 0, 1'b0);
        chk("post1.const", q, 1024);

        // Randomized stream with gaps and occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic v, c;
            int   x;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            x = int'($urandom_range(0, 4095)) - 2048;
            step("rnd", v, x, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
